fir_xifu_ctrl: RTL and testbench
================================

# fir_xifu_ctrl

In-order issue/commit/retire scoreboard for the FIR XIFU coprocessor. It records every instruction accepted by the decode stage. It matches core commit/kill messages against those instructions and gates the execute stage, so that no memory request or register write-back happens before the core has committed the instruction. It also generates the pipeline `ready` back-pressure and retires entries in program order.

## Interface
- `NB_ENTRIES`, 4: scoreboard depth; power of two, 2..16.
- `ID_WIDTH`, 4: width of the XIF instruction id.
- `clk_i  in  1  clock`
- `rst_ni  in  1  reset, asynchronous, active-low`
- `clear_i  in  1  synchronous flush of all entries`
- `issue_i  in  1  decode accepted an instruction this cycle`
- `issue_id_i  in  ID_WIDTH  id of the issued instruction`
- `commit_valid_i  in  1  core commit message valid`
- `commit_id_i  in  ID_WIDTH  id being committed`
- `commit_kill_i  in  1  1 = kill, 0 = commit`
- `retire_i  in  1  EX/WB finished the head instruction`
- `retire_id_i  in  ID_WIDTH  id of the finished instruction`
- `ready_o  out  1  scoreboard can accept an issue (drives decode/EX ready)`
- `head_valid_o  out  1  head entry occupied`
- `head_id_o  out  ID_WIDTH  id of the oldest entry`
- `head_committed_o  out  1  head entry committed, side effects allowed`
- `head_killed_o  out  1  head entry killed, EX must squash`
- `count_o  out  $clog2(NB_ENTRIES)+1  occupied entries`
- `error_o  out  1  one-cycle pulse on a protocol violation`

## Operation
- Circular buffer of `NB_ENTRIES` with head and tail pointers and an occupancy counter.
- Each entry holds `id` and a state: FREE, ISSUED, COMMITTED, or KILLED.
- **Issue:** when `issue_i & ready_o`, write `{issue_id_i, ISSUED}` at the tail, then tail+1 and count+1.
- **Commit:** when `commit_valid_i`, search the ISSUED entries for `id == commit_id_i`.
  - On a match, the entry moves to KILLED if `commit_kill_i`, otherwise to COMMITTED.
  - Only the oldest matching entry is affected.
- **Issue/commit bypass:** if a commit targets the id being issued in the same cycle and no older ISSUED entry matches, the new entry is written directly as COMMITTED or KILLED.
- **Retire:** when `retire_i`, the head is COMMITTED or KILLED, and `head_id_o == retire_id_i`:
  - the head entry becomes FREE;
  - head+1 and count-1.
- **Simultaneous issue and retire:** count is unchanged and both pointers advance.
- **Pointer wrap:** modulo `NB_ENTRIES`.
- **error_o pulses (state unchanged by the offending request)** for any of:
  - `issue_i` while `~ready_o`; the issue is dropped;
  - commit with no matching ISSUED entry, including an already committed or killed id;
  - `retire_i` with an empty buffer, an id mismatch, or a head still ISSUED.
- **clear_i:** all entries FREE, pointers and count 0. It has priority over issue, commit, and retire in the same cycle.
- **Head outputs:**
  - `head_valid_o = count != 0`;
  - `head_committed_o` / `head_killed_o` decode the head entry state and are 0 when empty.

## Timing
- All state is registered. Every output is a function of registered state only; there are no input-to-output combinational paths.
- `ready_o = count_o != NB_ENTRIES`.
  - It does not see a same-cycle retire: a full buffer accepts again one cycle after a retire.
- Effect latency:
  - issue is visible in `count_o` the next cycle;
  - commit is visible in `head_committed_o` / `head_killed_o` the next cycle;
  - retire advances the head the next cycle.
- `error_o` is registered and asserted in the cycle after the offending request, for exactly one cycle.
- **Reset values:**
  - `ready_o = 1`;
  - `head_valid_o = 0`, `head_id_o = 0`, `head_committed_o = 0`, `head_killed_o = 0`;
  - `count_o = 0`, `error_o = 0`;
  - all entries FREE.
- **Reset or clear mid-operation:** all in-flight entries are discarded with no retire. The first issue afterwards lands in entry 0.

## Test plan
- **Fill and full (NB_ENTRIES=4):**
  - stimulus: issue ids 1, 2, 3, 4 on consecutive cycles;
  - required: `count_o` = 1, 2, 3, 4; `ready_o` drops the cycle after the 4th issue; a 5th issue (id 5) pulses `error_o` and `count_o` stays 4.
- **Commit gating:**
  - stimulus: issue id 7; commit id 7 two cycles later;
  - required: `head_committed_o` = 0 until the cycle after the commit, then 1; `retire_i` with id 7 empties the buffer and `head_valid_o` = 0 the next cycle.
- **Kill path:**
  - stimulus: issue ids 3 and 4; kill id 3; commit id 4;
  - required: `head_killed_o` = 1 with `head_id_o` = 3; after retiring 3, `head_id_o` = 4 and `head_committed_o` = 1.
- **Bypass and simultaneous events:**
  - stimulus: issue id 9 with commit id 9 in the same cycle, while the buffer holds 2 committed entries; retire the head in that cycle;
  - required: the next cycle `count_o` = 2 and entry 9 is already COMMITTED; no `error_o`.
- **Wrap-around:**
  - stimulus: 10 issue/commit/retire rounds with ids 0..9 (`ID_WIDTH` 4);
  - required: retire order equals issue order; `count_o` never exceeds 4; no `error_o`.
- **Protocol errors and clear:**
  - stimulus: commit id 12 when not present; then retire while empty; then `clear_i` with 3 entries held;
  - required: `error_o` pulses once per violation; after clear, `count_o` = 0 and `ready_o` = 1.

Source files
------------

// File: rtl/fir_xifu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_xifu_ctrl_if
//  Description : Bundle of the issue / commit / retire handshake and the
//                scoreboard status outputs of fir_xifu_ctrl.
//                master : decode / core / EX side (drives requests)
//                slave  : the scoreboard (drives status)
//  Ports       : clear_i, issue_i, issue_id_i, commit_valid_i, commit_id_i,
//                commit_kill_i, retire_i, retire_id_i        (to scoreboard)
//                ready_o, head_valid_o, head_id_o, head_committed_o,
//                head_killed_o, count_o, error_o             (from scoreboard)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_xifu_ctrl_if #(
    parameter int NB_ENTRIES = 4,
    parameter int ID_WIDTH   = 4
);
    localparam int CNT_W = $clog2(NB_ENTRIES) + 1;

    logic                clear_i;
    logic                issue_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    logic                retire_i;
    logic [ID_WIDTH-1:0] retire_id_i;

    logic                ready_o;
    logic                head_valid_o;
    logic [ID_WIDTH-1:0] head_id_o;
    logic                head_committed_o;
    logic                head_killed_o;
    logic [CNT_W-1:0]    count_o;
    logic                error_o;

    modport master (
        output clear_i, issue_i, issue_id_i, commit_valid_i, commit_id_i,
               commit_kill_i, retire_i, retire_id_i,
        input  ready_o, head_valid_o, head_id_o, head_committed_o,
               head_killed_o, count_o, error_o
    );

    modport slave (
        input  clear_i, issue_i, issue_id_i, commit_valid_i, commit_id_i,
               commit_kill_i, retire_i, retire_id_i,
        output ready_o, head_valid_o, head_id_o, head_committed_o,
               head_killed_o, count_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/fir_xifu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fir_xifu_ctrl
//  Description : In-order issue/commit/retire scoreboard for the FIR XIFU
//                coprocessor. Tracks every decoded instruction, applies core
//                commit/kill messages to the oldest matching ISSUED entry,
//                exposes the head entry so EX only performs side effects once
//                committed, and retires entries in program order.
//  Ports       : clk_i  - clock
//                rst_ni - asynchronous active-low reset
//                bus    - fir_xifu_ctrl_if.slave (requests in, status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_xifu_ctrl #(
    parameter int NB_ENTRIES = 4,
    parameter int ID_WIDTH   = 4
) (
    input  wire logic           clk_i,
    input  wire logic           rst_ni,
    fir_xifu_ctrl_if.slave      bus
);
    localparam int PTR_W = $clog2(NB_ENTRIES);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(NB_ENTRIES);

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_ISSUED    = 2'd1,
        ST_COMMITTED = 2'd2,
        ST_KILLED    = 2'd3
    } entry_state_e;

    entry_state_e        r_state [NB_ENTRIES];
    logic [ID_WIDTH-1:0] r_id    [NB_ENTRIES];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_error;

    logic             w_ready;
    logic             w_issue_ok;
    logic             w_issue_err;
    logic             w_match;
    logic [PTR_W-1:0] w_match_idx;
    logic             w_bypass;
    logic             w_commit_err;
    logic             w_head_done;
    logic             w_retire_ok;
    logic             w_retire_err;
    entry_state_e     w_resolved;

    assign w_ready     = (r_count != c_full);
    assign w_issue_ok  = bus.issue_i & w_ready;
    assign w_issue_err = bus.issue_i & ~w_ready;

    // Walk from the head so the first hit is the oldest matching entry.
    // Only occupied slots can be ISSUED, so no occupancy check is needed.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int k = 0; k < NB_ENTRIES; k++) begin
            if (!w_match
                && r_state[r_head + PTR_W'(k)] == ST_ISSUED
                && r_id[r_head + PTR_W'(k)] == bus.commit_id_i) begin
                w_match     = 1'b1;
                w_match_idx = r_head + PTR_W'(k);
            end
        end
    end

    assign w_resolved   = bus.commit_kill_i ? ST_KILLED : ST_COMMITTED;
    // A commit for the instruction being issued right now lands directly in
    // the new entry, but only if no older in-flight copy of that id exists.
    assign w_bypass     = bus.commit_valid_i & ~w_match & w_issue_ok
                          & (bus.issue_id_i == bus.commit_id_i);
    assign w_commit_err = bus.commit_valid_i & ~w_match & ~w_bypass;

    assign w_head_done  = (r_state[r_head] == ST_COMMITTED)
                          || (r_state[r_head] == ST_KILLED);
    assign w_retire_ok  = bus.retire_i && (r_count != '0) && w_head_done
                          && (r_id[r_head] == bus.retire_id_i);
    assign w_retire_err = bus.retire_i & ~w_retire_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_ENTRIES; i++) begin
                r_state[i] <= ST_FREE;
                r_id[i]    <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else if (bus.clear_i) begin
            for (int i = 0; i < NB_ENTRIES; i++) begin
                r_state[i] <= ST_FREE;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            // Commit targets an ISSUED entry, retire a resolved head and issue
            // a free tail slot, so the three writes never hit the same entry.
            if (bus.commit_valid_i && w_match) begin
                r_state[w_match_idx] <= w_resolved;
            end
            if (w_retire_ok) begin
                r_state[r_head] <= ST_FREE;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_issue_ok) begin
                r_id[r_tail]    <= bus.issue_id_i;
                r_state[r_tail] <= w_bypass ? w_resolved : ST_ISSUED;
                r_tail          <= r_tail + PTR_W'(1);
            end
            case ({w_issue_ok, w_retire_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_error <= w_issue_err | w_commit_err | w_retire_err;
        end
    end

    assign bus.ready_o          = w_ready;
    assign bus.head_valid_o     = (r_count != '0);
    assign bus.head_id_o        = (r_count != '0) ? r_id[r_head] : '0;
    assign bus.head_committed_o = (r_count != '0) && (r_state[r_head] == ST_COMMITTED);
    assign bus.head_killed_o    = (r_count != '0) && (r_state[r_head] == ST_KILLED);
    assign bus.count_o          = r_count;
    assign bus.error_o          = r_error;
endmodule
`default_nettype wire

// File: tb/tb_fir_xifu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_xifu_ctrl
//  Description : Self-checking bench for fir_xifu_ctrl. A queue-of-entries
//                reference model predicts every output after every clock;
//                directed scenarios are followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_xifu_ctrl;
    localparam int NB_ENTRIES = 4;
    localparam int ID_WIDTH   = 4;
    localparam int M_ISSUED    = 1;
    localparam int M_COMMITTED = 2;
    localparam int M_KILLED    = 3;

    typedef struct {
        int unsigned id;
        int          st;
    } ent_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    fir_xifu_ctrl_if #(.NB_ENTRIES(NB_ENTRIES), .ID_WIDTH(ID_WIDTH)) bus ();

    fir_xifu_ctrl #(.NB_ENTRIES(NB_ENTRIES), .ID_WIDTH(ID_WIDTH)) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    ent_t q[$];
    int   m_err;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit iss, input int unsigned iid, input bit cv,
                         input int unsigned cid, input bit kill, input bit ret,
                         input int unsigned rid, input bit clr);
        bus.issue_i        = iss;
        bus.issue_id_i     = ID_WIDTH'(iid);
        bus.commit_valid_i = cv;
        bus.commit_id_i    = ID_WIDTH'(cid);
        bus.commit_kill_i  = kill;
        bus.retire_i       = ret;
        bus.retire_id_i    = ID_WIDTH'(rid);
        bus.clear_i        = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference: apply one clock's requests to the in-order entry list.
    task automatic model_step();
        bit iss_ok, ret_ok, byp;
        int hit;
        if (bus.clear_i) begin
            q.delete();
            m_err = 0;
            return;
        end
        m_err  = 0;
        iss_ok = bus.issue_i && (q.size() < NB_ENTRIES);
        if (bus.issue_i && !iss_ok) m_err = 1;
        ret_ok = bus.retire_i && (q.size() > 0) && (q[0].st != M_ISSUED)
                 && (q[0].id == int'(bus.retire_id_i));
        hit = -1;
        for (int i = 0; i < q.size(); i++)
            if (hit < 0 && q[i].st == M_ISSUED && q[i].id == int'(bus.commit_id_i)) hit = i;
        byp = 0;
        if (bus.commit_valid_i) begin
            if (hit >= 0) q[hit].st = bus.commit_kill_i ? M_KILLED : M_COMMITTED;
            else if (iss_ok && bus.issue_id_i == bus.commit_id_i) byp = 1;
            else m_err = 1;
        end
        if (bus.retire_i) begin
            if (ret_ok) void'(q.pop_front());
            else m_err = 1;
        end
        if (iss_ok) begin
            ent_t e;
            e.id = int'(bus.issue_id_i);
            e.st = byp ? (bus.commit_kill_i ? M_KILLED : M_COMMITTED) : M_ISSUED;
            q.push_back(e);
        end
    endtask

    task automatic compare_all(input string tag);
        int unsigned n;
        n = q.size();
        chk({tag, ":count"}, bus.count_o, n);
        chk({tag, ":ready"}, bus.ready_o, (n != NB_ENTRIES) ? 1 : 0);
        chk({tag, ":hvalid"}, bus.head_valid_o, (n != 0) ? 1 : 0);
        chk({tag, ":error"}, bus.error_o, m_err);
        if (n != 0) begin
            chk({tag, ":hid"}, bus.head_id_o, q[0].id);
            chk({tag, ":hcommit"}, bus.head_committed_o, (q[0].st == M_COMMITTED) ? 1 : 0);
            chk({tag, ":hkill"}, bus.head_killed_o, (q[0].st == M_KILLED) ? 1 : 0);
        end else begin
            chk({tag, ":hcommit"}, bus.head_committed_o, 0);
            chk({tag, ":hkill"}, bus.head_killed_o, 0);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk_i);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, ":ready"}, bus.ready_o, 1);
        chk({tag, ":hvalid"}, bus.head_valid_o, 0);
        chk({tag, ":hid"}, bus.head_id_o, 0);
        chk({tag, ":hcommit"}, bus.head_committed_o, 0);
        chk({tag, ":hkill"}, bus.head_killed_o, 0);
        chk({tag, ":count"}, bus.count_o, 0);
        chk({tag, ":error"}, bus.error_o, 0);
    endtask

    initial begin
        idle();
        q.delete();
        m_err = 0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_checks("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill and full
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, 0, 0, 0, 0, 0, 0);
            cycle("fill");
            chk("fill_count", bus.count_o, i);
        end
        chk("full_ready", bus.ready_o, 0);
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        cycle("overflow");
        chk("overflow_err", bus.error_o, 1);
        chk("overflow_count", bus.count_o, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cycle("clear1");

        // Commit gating
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        cycle("gate_issue");
        idle();
        cycle("gate_wait");
        chk("gate_pre", bus.head_committed_o, 0);
        drive(0, 0, 1, 7, 0, 0, 0, 0);
        cycle("gate_commit");
        chk("gate_post", bus.head_committed_o, 1);
        drive(0, 0, 0, 0, 0, 1, 7, 0);
        cycle("gate_retire");
        chk("gate_empty", bus.head_valid_o, 0);

        // Kill path
        drive(1, 3, 0, 0, 0, 0, 0, 0); cycle("kill_i3");
        drive(1, 4, 1, 3, 1, 0, 0, 0); cycle("kill_k3");
        drive(0, 0, 1, 4, 0, 0, 0, 0); cycle("kill_c4");
        chk("kill_head", bus.head_killed_o, 1);
        chk("kill_hid", bus.head_id_o, 3);
        drive(0, 0, 0, 0, 0, 1, 3, 0); cycle("kill_r3");
        chk("kill_next_id", bus.head_id_o, 4);
        chk("kill_next_c", bus.head_committed_o, 1);
        drive(0, 0, 0, 0, 0, 1, 4, 0); cycle("kill_r4");

        // Bypass with simultaneous retire
        drive(1, 1, 0, 0, 0, 0, 0, 0); cycle("byp_i1");
        drive(1, 2, 1, 1, 0, 0, 0, 0); cycle("byp_i2");
        drive(0, 0, 1, 2, 0, 0, 0, 0); cycle("byp_c2");
        drive(1, 9, 1, 9, 0, 1, 1, 0); cycle("byp_main");
        chk("byp_count", bus.count_o, 2);
        chk("byp_noerr", bus.error_o, 0);
        chk("byp_state", (q.size() == 2 && q[1].st == M_COMMITTED) ? 1 : 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle("clear2");

        // Wrap-around
        for (int i = 0; i < 10; i++) begin
            drive(1, i, 0, 0, 0, 0, 0, 0); cycle("wrap_i");
            drive(0, 0, 1, i, 0, 0, 0, 0); cycle("wrap_c");
            drive(0, 0, 0, 0, 0, 1, i, 0); cycle("wrap_r");
            chk("wrap_noerr", bus.error_o, 0);
        end

        // Protocol errors and clear
        idle();
        drive(0, 0, 1, 12, 0, 0, 0, 0); cycle("err_commit");
        chk("err_commit_pulse", bus.error_o, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 0); cycle("err_retire");
        chk("err_retire_pulse", bus.error_o, 1);
        idle(); cycle("err_gap");
        chk("err_single", bus.error_o, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, i + 5, 0, 0, 0, 0, 0, 0); cycle("pre_clear");
        end
        drive(1, 11, 1, 5, 0, 1, 5, 1); cycle("clear3");
        chk("clear_count", bus.count_o, 0);
        chk("clear_ready", bus.ready_o, 1);

        // Randomized traffic with one asynchronous reset mid-run
        for (int n = 0; n < 2000; n++) begin
            bit iss, cv, kill, ret, clr;
            int unsigned iid, cid, rid;
            int nis;
            int pick;
            iss  = ($urandom_range(0, 99) < 55);
            iid  = $urandom_range(0, 15);
            kill = ($urandom_range(0, 3) == 0);
            cv   = ($urandom_range(0, 99) < 50);
            cid  = $urandom_range(0, 15);
            nis  = 0;
            foreach (q[i]) if (q[i].st == M_ISSUED) nis++;
            if (cv && nis > 0 && $urandom_range(0, 99) < 80) begin
                pick = $urandom_range(0, nis - 1);
                foreach (q[i]) if (q[i].st == M_ISSUED) begin
                    if (pick == 0) cid = q[i].id;
                    pick--;
                end
            end else if (cv && iss && $urandom_range(0, 1) == 1) begin
                cid = iid;
            end
            ret = 0;
            rid = $urandom_range(0, 15);
            if (q.size() > 0 && q[0].st != M_ISSUED && $urandom_range(0, 99) < 70) begin
                ret = 1;
                rid = q[0].id;
            end else if ($urandom_range(0, 99) < 5) begin
                ret = 1;
            end
            clr = ($urandom_range(0, 199) == 0);
            drive(iss, iid, cv, cid, kill, ret, rid, clr);
            cycle("rand");
            if (n == 1000) begin
                idle();
                rst_ni = 1'b0;
                #2;
                q.delete();
                m_err = 0;
                reset_checks("midreset");
                @(negedge clk_i);
                rst_ni = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
